vector_matmul_engine: RTL and testbench
=======================================

Name: vector_matmul_engine

Overview:
- Parametrised successor to the single-channel CNN MAC path.
- Computes y = A·x. A is a ROWS×COLS signed integer matrix and x is a length-COLS vector; both are held in internal banked operand stores.
- Processes VECTOR_SIZE lanes per cycle, masks tail lanes, and supports optional ReLU on each output.
- Streams one result per row into an output FIFO with ready/valid backpressure. Sits between the RISCV bus write path and the downstream result consumer.

Parameters:
- DATA_WIDTH, 16: signed operand element width.
- VECTOR_SIZE, 8: lanes (multipliers) per cycle; power of two ≥ 1.
- MAX_SIZE, 1024: element capacity of each of store A and store X.
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(MAX_SIZE): signed accumulator and result width.
- FIFO_DEPTH, 16: output FIFO entries; power of two ≥ 4.

Ports:
- clkIn in 1: clock.
- rstIn in 1: reset, asynchronous, active-low.
- wrEnIn in 1: operand write strobe.
- wrSelIn in 1: 0 = store A, 1 = store X.
- wrAddrIn in $clog2(MAX_SIZE): element index. A is row-major, index = r*cols+c.
- wrDataIn in DATA_WIDTH: element value.
- rowsIn in $clog2(MAX_SIZE)+1: row count, sampled on start.
- colsIn in $clog2(MAX_SIZE)+1: column count, sampled on start.
- reluIn in 1: clamp negative results to 0, sampled on start.
- startIn in 1: start pulse.
- busyOut out 1: job in progress.
- doneOut out 1: one-cycle pulse at job completion.
- errOut out 1: one-cycle pulse on a rejected start.
- validOut out 1: FIFO head valid.
- dataOut out ACC_WIDTH: FIFO head result.
- readyIn in 1: consumer ready.

Behaviour:
- Reset values: busyOut=0, doneOut=0, errOut=0, validOut=0, dataOut=0. FIFO is emptied, state is IDLE, counters and pipeline valids are cleared. Operand stores are not reset.
- Reset mid-job aborts the job and discards in-flight and queued results.
- Writes:
  - Accepted only while IDLE and wrAddrIn < MAX_SIZE; ignored otherwise.
  - Write takes effect at the clock edge; the element is readable by a job started the next cycle.
- States:
  - IDLE: on startIn, if rowsIn==0, colsIn==0, colsIn>MAX_SIZE or rowsIn*colsIn>MAX_SIZE, pulse errOut next cycle and stay IDLE. Otherwise latch the config and go to RUN; busyOut=1 from the next cycle.
  - RUN: issue one chunk per cycle. The chunk covers row r, columns c..c+VECTOR_SIZE-1; lane i is enabled iff c+i < cols. After the last chunk of a row, increment r and set c=0. After the last chunk of the last row, go to DRAIN.
  - DRAIN: wait for the pipeline to empty. Then pulse doneOut, drop busyOut and go to IDLE.
- startIn is ignored while not IDLE.
- Datapath pipeline:
  - Stage 1 registers lane products, each signed DATA_WIDTH×DATA_WIDTH → 2*DATA_WIDTH; masked lanes are 0.
  - Stage 2 sums the lanes (adder tree, sign-extended to ACC_WIDTH) into the accumulator. The accumulator is cleared at the first chunk of each row.
  - The row-end flag travels with the chunk. On row end, acc+sum (ReLU applied if enabled) is written to the FIFO on the following edge.
- ACC_WIDTH is sized so that no overflow is possible; no saturation logic is required.
- Latency: with the FIFO empty and cols ≤ VECTOR_SIZE, validOut rises 3 cycles after the edge that samples startIn. Each further row adds ceil(cols/VECTOR_SIZE) cycles.
- Backpressure:
  - A chunk that begins a new row issues only when fifoCount + rowsInFlight < FIFO_DEPTH; otherwise issue stalls.
  - Chunks of a row already started never stall.
  - The FIFO therefore never overflows and no result is dropped.
- FIFO:
  - First-word fall-through; dataOut = head while validOut=1.
  - Pop occurs on validOut && readyIn.
  - Simultaneous push and pop on a full FIFO is legal and the count is unchanged.
  - dataOut holds its last value when the FIFO is empty.
- doneOut fires only after the last result has been pushed. The consumer may still be draining the FIFO after done; a new start is allowed and appends to the FIFO.

Test Plan:
- A=[1,2,3] (1×3), x=[4,5,6], VECTOR_SIZE=8, readyIn=1 -> single result 32; validOut rises 3 cycles after start; doneOut pulses once.
- 4×10 all-ones A, x=[1..10], VECTOR_SIZE=8 (tail masks 6 lanes) -> four results of 55, two chunks per row, 8 RUN cycles.
- A row [-3,1], x=[2,2], reluIn=1 -> result 0. Same job with reluIn=0 -> result -4, sign-extended to ACC_WIDTH.
- 40 rows, cols=1, FIFO_DEPTH=16, readyIn=0 -> issue stalls with 16 entries queued and busyOut held. Then set readyIn=1 -> all 40 results arrive in order with none lost, then doneOut.
- startIn with rowsIn=0, and separately with rowsIn*colsIn=MAX_SIZE+1 -> errOut pulses 1 cycle, busyOut stays 0, no output.
- Drop rstIn mid-RUN with 3 results queued -> validOut=0 immediately. Restart the same job -> full correct result set.

Source files
------------

// File: rtl/vector_matmul_engine.sv
// Matrix-vector engine y = A*x over banked operand stores, VECTOR_SIZE lanes per cycle,
// optional ReLU, results streamed through a first-word fall-through output FIFO.
module vector_matmul_engine #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned VECTOR_SIZE = 8,
  parameter int unsigned MAX_SIZE    = 1024,
  parameter int unsigned ACC_WIDTH   = 2*DATA_WIDTH + $clog2(MAX_SIZE),
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic                        clkIn,
  input  logic                        rstIn,
  input  logic                        wrEnIn,
  input  logic                        wrSelIn,
  input  logic [$clog2(MAX_SIZE)-1:0] wrAddrIn,
  input  logic [DATA_WIDTH-1:0]       wrDataIn,
  input  logic [$clog2(MAX_SIZE):0]   rowsIn,
  input  logic [$clog2(MAX_SIZE):0]   colsIn,
  input  logic                        reluIn,
  input  logic                        startIn,
  output logic                        busyOut,
  output logic                        doneOut,
  output logic                        errOut,
  output logic                        validOut,
  output logic [ACC_WIDTH-1:0]        dataOut,
  input  logic                        readyIn
);
  localparam int unsigned AW  = $clog2(MAX_SIZE);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned IW  = CW + $clog2(VECTOR_SIZE) + 1;
  localparam int unsigned PW  = 2 * DATA_WIDTH;
  localparam int unsigned FAW = $clog2(FIFO_DEPTH);
  localparam int unsigned FCW = FAW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
  state_e state_q, state_d;

  logic signed [DATA_WIDTH-1:0] mem_a [MAX_SIZE];
  logic signed [DATA_WIDTH-1:0] mem_x [MAX_SIZE];
  logic [ACC_WIDTH-1:0]         fifo_mem [FIFO_DEPTH];

  logic [CW-1:0] rows_q, rows_d, cols_q, cols_d, row_q, row_d, col_q, col_d;
  logic [CW-1:0] row_base_q, row_base_d;
  logic          relu_q, relu_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic          s1_valid_q, s1_valid_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d;
  logic signed [PW-1:0] s1_prod_q [VECTOR_SIZE];
  logic signed [PW-1:0] s1_prod_d [VECTOR_SIZE];
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, res_q, res_d, lane_sum;
  logic          res_valid_q, res_valid_d;
  logic [FCW-1:0] count_q, count_d, inflight_q, inflight_d;
  logic [FAW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0] out_data_q, out_data_d;

  logic [2*CW-1:0] cfg_area;
  logic cfg_ok, start_ok, start_bad, wr_ok;
  logic first_chunk, last_in_row, last_row, room, issue, pipe_empty, push, pop;
  logic [IW-1:0] x_idx;
  logic [AW-1:0] a_idx;

  assign cfg_area    = (2*CW)'(rowsIn) * (2*CW)'(colsIn);
  assign cfg_ok      = (rowsIn != '0) && (colsIn != '0) && (32'(colsIn) <= MAX_SIZE)
                       && (cfg_area <= (2*CW)'(MAX_SIZE));
  assign start_ok    = (state_q == IDLE) && startIn && cfg_ok;
  assign start_bad   = (state_q == IDLE) && startIn && !cfg_ok;
  assign wr_ok       = wrEnIn && (state_q == IDLE) && (32'(wrAddrIn) < MAX_SIZE);
  assign first_chunk = (col_q == '0);
  assign last_in_row = (IW'(col_q) + IW'(VECTOR_SIZE)) >= IW'(cols_q);
  assign last_row    = (row_q == rows_q - CW'(1));
  // A new row may only start if its result is guaranteed a FIFO slot.
  assign room        = (32'(count_q) + 32'(inflight_q)) < FIFO_DEPTH;
  assign issue       = (state_q == RUN) && (!first_chunk || room);
  assign pipe_empty  = !s1_valid_q && !res_valid_q;
  assign push        = res_valid_q;
  assign pop         = out_valid_q && readyIn;

  // Operand stores: written only while idle, never reset.
  always_ff @(posedge clkIn) begin
    if (wr_ok) begin
      if (wrSelIn) mem_x[wrAddrIn] <= wrDataIn;
      else         mem_a[wrAddrIn] <= wrDataIn;
    end
  end

  always_ff @(posedge clkIn) begin
    if (push) fifo_mem[wr_ptr_q] <= res_q;
  end

  // Lane products for the current chunk; lanes past the row end contribute 0.
  always_comb begin
    x_idx = '0;
    a_idx = '0;
    for (int i = 0; i < int'(VECTOR_SIZE); i++) begin
      x_idx        = IW'(col_q) + IW'(i);
      a_idx        = AW'(row_base_q) + AW'(x_idx);
      s1_prod_d[i] = '0;
      if (x_idx < IW'(cols_q))
        s1_prod_d[i] = PW'(mem_a[a_idx]) * PW'(mem_x[AW'(x_idx)]);
    end
  end

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < int'(VECTOR_SIZE); i++)
      lane_sum = lane_sum + ACC_WIDTH'(s1_prod_q[i]);
  end

  // Job config, chunk sequencing and accumulator.
  always_comb begin
    rows_d      = rows_q;
    cols_d      = cols_q;
    relu_d      = relu_q;
    row_d       = row_q;
    col_d       = col_q;
    row_base_d  = row_base_q;
    s1_valid_d  = issue;
    s1_first_d  = issue && first_chunk;
    s1_last_d   = issue && last_in_row;
    acc_d       = acc_q;
    res_valid_d = 1'b0;
    res_d       = res_q;
    if (start_ok) begin
      rows_d     = rowsIn;
      cols_d     = colsIn;
      relu_d     = reluIn;
      row_d      = '0;
      col_d      = '0;
      row_base_d = '0;
    end
    if (issue) begin
      if (last_in_row) begin
        col_d      = '0;
        row_d      = row_q + CW'(1);
        row_base_d = row_base_q + cols_q;
      end else begin
        col_d      = col_q + CW'(VECTOR_SIZE);
      end
    end
    if (s1_valid_q) begin
      acc_d = (s1_first_q ? ACC_WIDTH'(0) : acc_q) + lane_sum;
      if (s1_last_q) begin
        res_valid_d = 1'b1;
        res_d       = (relu_q && acc_d[ACC_WIDTH-1]) ? '0 : acc_d;
      end
    end
    inflight_d = inflight_q + FCW'(issue && first_chunk) - FCW'(push);
  end

  // FIFO pointers and registered head; head holds its last value when empty.
  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + FAW'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + FAW'(1) : rd_ptr_q;
    count_d     = count_q + FCW'(push) - FCW'(pop);
    out_valid_d = (count_d != '0);
    out_data_d  = out_data_q;
    if (count_d != '0)
      out_data_d = (push && (wr_ptr_q == rd_ptr_d)) ? res_q : fifo_mem[rd_ptr_d];
  end

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = RUN;
      RUN:     if (issue && last_in_row && last_row) state_d = DRAIN;
      DRAIN:   if (pipe_empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok)  busy_d = 1'b1;
        if (start_bad) err_d  = 1'b1;
      end
      DRAIN: begin
        if (pipe_empty) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      rows_q <= '0; cols_q <= '0; relu_q <= 1'b0;
      row_q <= '0; col_q <= '0; row_base_q <= '0;
      busy_q <= 1'b0; done_q <= 1'b0; err_q <= 1'b0;
      s1_valid_q <= 1'b0; s1_first_q <= 1'b0; s1_last_q <= 1'b0;
      for (int i = 0; i < int'(VECTOR_SIZE); i++) s1_prod_q[i] <= '0;
      acc_q <= '0; res_q <= '0; res_valid_q <= 1'b0;
      count_q <= '0; inflight_q <= '0; wr_ptr_q <= '0; rd_ptr_q <= '0;
      out_valid_q <= 1'b0; out_data_q <= '0;
    end else begin
      rows_q <= rows_d; cols_q <= cols_d; relu_q <= relu_d;
      row_q <= row_d; col_q <= col_d; row_base_q <= row_base_d;
      busy_q <= busy_d; done_q <= done_d; err_q <= err_d;
      s1_valid_q <= s1_valid_d; s1_first_q <= s1_first_d; s1_last_q <= s1_last_d;
      for (int i = 0; i < int'(VECTOR_SIZE); i++) s1_prod_q[i] <= s1_prod_d[i];
      acc_q <= acc_d; res_q <= res_d; res_valid_q <= res_valid_d;
      count_q <= count_d; inflight_q <= inflight_d; wr_ptr_q <= wr_ptr_d; rd_ptr_q <= rd_ptr_d;
      out_valid_q <= out_valid_d; out_data_q <= out_data_d;
    end
  end

  assign busyOut  = busy_q;
  assign doneOut  = done_q;
  assign errOut   = err_q;
  assign validOut = out_valid_q;
  assign dataOut  = out_data_q;
endmodule

// File: tb/tb_vector_matmul_engine.sv
// Bench for vector_matmul_engine: directed scenarios plus randomized jobs checked
// against a plain-arithmetic matrix-vector reference model.
module tb_vector_matmul_engine;
  localparam int unsigned DW    = 16;
  localparam int unsigned VS    = 8;
  localparam int unsigned MS    = 1024;
  localparam int unsigned AW    = 10;
  localparam int unsigned CWB   = AW + 1;
  localparam int unsigned ACC_W = 2*DW + AW;
  localparam int unsigned FD    = 16;

  logic             clkIn = 1'b0, rstIn = 1'b1;
  logic             wrEnIn = 1'b0, wrSelIn = 1'b0, reluIn = 1'b0, startIn = 1'b0, readyIn = 1'b1;
  logic [AW-1:0]    wrAddrIn = '0;
  logic [DW-1:0]    wrDataIn = '0;
  logic [CWB-1:0]   rowsIn = '0, colsIn = '0;
  logic             busyOut, doneOut, errOut, validOut;
  logic [ACC_W-1:0] dataOut;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int a_m [MS];
  int x_m [MS];
  logic [ACC_W-1:0] got_q [$];
  logic [ACC_W-1:0] exp_q [$];

  vector_matmul_engine #(.DATA_WIDTH(DW), .VECTOR_SIZE(VS), .MAX_SIZE(MS), .FIFO_DEPTH(FD)) dut (
    .clkIn(clkIn), .rstIn(rstIn), .wrEnIn(wrEnIn), .wrSelIn(wrSelIn), .wrAddrIn(wrAddrIn),
    .wrDataIn(wrDataIn), .rowsIn(rowsIn), .colsIn(colsIn), .reluIn(reluIn), .startIn(startIn),
    .busyOut(busyOut), .doneOut(doneOut), .errOut(errOut), .validOut(validOut),
    .dataOut(dataOut), .readyIn(readyIn)
  );

  always #5 clkIn = ~clkIn;

  always @(negedge clkIn) begin
    if (rstIn && validOut && readyIn) got_q.push_back(dataOut);
    if (doneOut) done_cnt++;
    if (errOut) err_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic longint model_row(input int r, input int cols, input bit relu);
    longint s = 0;
    for (int c = 0; c < cols; c++) s += longint'(a_m[r*cols + c]) * longint'(x_m[c]);
    if (relu && s < 0) s = 0;
    return s;
  endfunction

  task automatic build_expect(input int rows, input int cols, input bit relu);
    longint s;
    exp_q.delete();
    for (int r = 0; r < rows; r++) begin
      s = model_row(r, cols, relu);
      exp_q.push_back(s[ACC_W-1:0]);
    end
  endtask

  task automatic write_elem(input bit sel, input int addr, input logic [DW-1:0] val);
    wrEnIn = 1'b1; wrSelIn = sel; wrAddrIn = AW'(addr); wrDataIn = val;
    @(posedge clkIn); #1;
    wrEnIn = 1'b0;
    if (sel) x_m[addr] = $signed(val);
    else     a_m[addr] = $signed(val);
  endtask

  task automatic load_random(input int rows, input int cols);
    for (int i = 0; i < rows*cols; i++) write_elem(1'b0, i, DW'($urandom));
    for (int c = 0; c < cols; c++) write_elem(1'b1, c, DW'($urandom));
  endtask

  task automatic drive_job(input int rows, input int cols, input bit relu, input bit rand_ready,
                           output int valid_edges, output int done_edges, output bit timeout);
    rowsIn = CWB'(rows); colsIn = CWB'(cols); reluIn = relu; startIn = 1'b1;
    @(posedge clkIn); #1;
    startIn = 1'b0;
    valid_edges = -1; done_edges = 0; timeout = 1'b0;
    while (doneOut !== 1'b1 && !timeout) begin
      if (rand_ready) readyIn = 1'($urandom_range(0, 1));
      @(posedge clkIn); #1;
      done_edges++;
      if (validOut === 1'b1 && valid_edges < 0) valid_edges = done_edges;
      if (done_edges > 20000) timeout = 1'b1;
    end
    readyIn = 1'b1;
  endtask

  task automatic wait_results(input int n, output bit timeout);
    int k = 0;
    readyIn = 1'b1;
    timeout = 1'b0;
    while (got_q.size() < n && !timeout) begin
      @(posedge clkIn); #1;
      k++;
      if (k > 5000) timeout = 1'b1;
    end
    repeat (4) @(posedge clkIn);
    #1;
  endtask

  task automatic test_reset();
    rstIn = 1'b0;
    repeat (3) @(posedge clkIn);
    #1;
    n_checks++; if (busyOut !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busyOut); end
    n_checks++; if (doneOut !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", doneOut); end
    n_checks++; if (errOut !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b want 0", errOut); end
    n_checks++; if (validOut !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", validOut); end
    n_checks++; if (dataOut !== '0) begin n_fail++; $display("FAIL reset_data: got %0h want 0", dataOut); end
    rstIn = 1'b1;
    @(posedge clkIn); #1;
  endtask

  task automatic test_single();
    int ve, de, d0; bit to_d, to_r;
    write_elem(0, 0, 16'd1); write_elem(0, 1, 16'd2); write_elem(0, 2, 16'd3);
    write_elem(1, 0, 16'd4); write_elem(1, 1, 16'd5); write_elem(1, 2, 16'd6);
    got_q.delete(); d0 = done_cnt;
    build_expect(1, 3, 0);
    drive_job(1, 3, 0, 0, ve, de, to_d);
    n_checks++; if (to_d || ve != 3) begin n_fail++; $display("FAIL single_latency: valid after %0d edges want 3", ve); end
    n_checks++; if (de != 4) begin n_fail++; $display("FAIL single_done_edges: got %0d want 4", de); end
    @(posedge clkIn); #1;
    n_checks++; if (doneOut !== 1'b0 || busyOut !== 1'b0) begin n_fail++; $display("FAIL single_done_pulse: done %0b busy %0b want 0 0", doneOut, busyOut); end
    wait_results(1, to_r);
    n_checks++; if (got_q.size() != 1 || done_cnt - d0 != 1) begin n_fail++; $display("FAIL single_count: results %0d dones %0d want 1 1", got_q.size(), done_cnt - d0); end
    n_checks++; if (got_q.size() > 0 && got_q[0] !== ACC_W'(32)) begin n_fail++; $display("FAIL single_value: got %0d want 32", got_q[0]); end
  endtask

  task automatic test_tail();
    int ve, de; bit to_d, to_r;
    for (int i = 0; i < 40; i++) write_elem(0, i, 16'd1);
    for (int c = 0; c < 10; c++) write_elem(1, c, DW'(c + 1));
    got_q.delete();
    build_expect(4, 10, 0);
    drive_job(4, 10, 0, 0, ve, de, to_d);
    n_checks++; if (to_d || ve != 4 || de != 11) begin n_fail++; $display("FAIL tail_timing: valid %0d done %0d want 4 11", ve, de); end
    wait_results(4, to_r);
    n_checks++; if (got_q.size() != 4) begin n_fail++; $display("FAIL tail_count: got %0d want 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== ACC_W'(55)) begin n_fail++; $display("FAIL tail_value[%0d]: got %0d want 55", i, got_q[i]); end
    end
  endtask

  task automatic test_relu();
    int ve, de; bit to_d, to_r;
    logic [ACC_W-1:0] m4;
    m4 = '1; m4 = m4 - ACC_W'(3);
    write_elem(0, 0, -16'sd3); write_elem(0, 1, 16'd1);
    write_elem(1, 0, 16'd2);   write_elem(1, 1, 16'd2);
    for (int pass = 0; pass < 2; pass++) begin
      got_q.delete();
      drive_job(1, 2, pass == 0, 0, ve, de, to_d);
      wait_results(1, to_r);
      n_checks++;
      if (got_q.size() != 1 || got_q[0] !== ((pass == 0) ? ACC_W'(0) : m4)) begin
        n_fail++;
        $display("FAIL relu_%0d: got %0h (n=%0d) want %0h", pass, (got_q.size() > 0) ? got_q[0] : 'x,
                 got_q.size(), (pass == 0) ? ACC_W'(0) : m4);
      end
    end
  endtask

  task automatic test_errors();
    int rows_t [3] = '{0, 5, 1};
    int cols_t [3] = '{3, 205, 1025};
    int e0;
    for (int t = 0; t < 3; t++) begin
      got_q.delete(); e0 = err_cnt;
      rowsIn = CWB'(rows_t[t]); colsIn = CWB'(cols_t[t]); startIn = 1'b1;
      @(posedge clkIn); #1;
      startIn = 1'b0;
      n_checks++; if (errOut !== 1'b1 || busyOut !== 1'b0) begin n_fail++; $display("FAIL err_pulse_%0d: err %0b busy %0b want 1 0", t, errOut, busyOut); end
      repeat (6) @(posedge clkIn);
      #1;
      n_checks++;
      if (err_cnt - e0 != 1 || busyOut !== 1'b0 || validOut !== 1'b0 || got_q.size() != 0) begin
        n_fail++;
        $display("FAIL err_quiet_%0d: errs %0d busy %0b valid %0b results %0d want 1 0 0 0",
                 t, err_cnt - e0, busyOut, validOut, got_q.size());
      end
    end
  endtask

  task automatic test_backpressure();
    int k, d0; bit to_r;
    for (int r = 0; r < 40; r++) write_elem(0, r, DW'($urandom));
    write_elem(1, 0, DW'($urandom));
    build_expect(40, 1, 0);
    got_q.delete(); d0 = done_cnt;
    readyIn = 1'b0;
    rowsIn = CWB'(40); colsIn = CWB'(1); reluIn = 1'b0; startIn = 1'b1;
    @(posedge clkIn); #1;
    startIn = 1'b0;
    repeat (100) @(posedge clkIn);
    #1;
    n_checks++;
    if (busyOut !== 1'b1 || validOut !== 1'b1 || done_cnt != d0 || dataOut !== exp_q[0]) begin
      n_fail++;
      $display("FAIL bp_stall: busy %0b valid %0b dones %0d head %0h want 1 1 0 %0h",
               busyOut, validOut, done_cnt - d0, dataOut, exp_q[0]);
    end
    // Busy-time write must be ignored; the model store is left untouched.
    wrEnIn = 1'b1; wrSelIn = 1'b1; wrAddrIn = '0; wrDataIn = ~DW'(x_m[0]);
    @(posedge clkIn); #1;
    wrEnIn = 1'b0;
    readyIn = 1'b1;
    k = 0;
    while (doneOut !== 1'b1 && k < 500) begin @(posedge clkIn); #1; k++; end
    n_checks++; if (k >= 500) begin n_fail++; $display("FAIL bp_done: no done within 500 cycles"); end
    wait_results(40, to_r);
    n_checks++; if (got_q.size() != 40) begin n_fail++; $display("FAIL bp_count: got %0d want 40", got_q.size()); end
    for (int i = 0; i < 40 && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_value[%0d]: got %0h want %0h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int ve, de; bit to_d, to_r;
    load_random(8, 20);
    build_expect(8, 20, 1);
    readyIn = 1'b0;
    rowsIn = CWB'(8); colsIn = CWB'(20); reluIn = 1'b1; startIn = 1'b1;
    @(posedge clkIn); #1;
    startIn = 1'b0;
    repeat (11) @(posedge clkIn);
    #1;
    n_checks++; if (validOut !== 1'b1 || busyOut !== 1'b1) begin n_fail++; $display("FAIL rmid_pre: valid %0b busy %0b want 1 1", validOut, busyOut); end
    rstIn = 1'b0;
    #1;
    n_checks++; if (validOut !== 1'b0 || busyOut !== 1'b0 || dataOut !== '0) begin n_fail++; $display("FAIL rmid_abort: valid %0b busy %0b data %0h want 0 0 0", validOut, busyOut, dataOut); end
    @(posedge clkIn); #1;
    rstIn = 1'b1;
    @(posedge clkIn); #1;
    got_q.delete();
    readyIn = 1'b1;
    drive_job(8, 20, 1, 0, ve, de, to_d);
    n_checks++; if (to_d || de != 8*3 + 3) begin n_fail++; $display("FAIL rmid_done_edges: got %0d want 27", de); end
    wait_results(8, to_r);
    n_checks++; if (got_q.size() != 8) begin n_fail++; $display("FAIL rmid_count: got %0d want 8", got_q.size()); end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rmid_value[%0d]: got %0h want %0h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_full_size();
    int ve, de; bit to_d, to_r;
    for (int i = 0; i < 1024; i++) write_elem(0, i, 16'h8000);
    for (int c = 0; c < 1024; c++) write_elem(1, c, 16'h8000);
    build_expect(1, 1024, 0);
    got_q.delete();
    drive_job(1, 1024, 0, 0, ve, de, to_d);
    n_checks++; if (to_d || de != 128 + 3) begin n_fail++; $display("FAIL full_done_edges: got %0d want 131", de); end
    wait_results(1, to_r);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      n_fail++;
      $display("FAIL full_value: got %0h (n=%0d) want %0h", (got_q.size() > 0) ? got_q[0] : 'x, got_q.size(), exp_q[0]);
    end
  endtask

  task automatic test_random();
    int rows, cols, ve, de; bit relu, to_d, to_r;
    for (int j = 0; j < 6; j++) begin
      rows = $urandom_range(1, 6);
      cols = (j == 0) ? 8 : (j == 1) ? 16 : $urandom_range(1, 40);
      relu = 1'($urandom_range(0, 1));
      load_random(rows, cols);
      build_expect(rows, cols, relu);
      got_q.delete();
      drive_job(rows, cols, relu, 1, ve, de, to_d);
      n_checks++;
      if (to_d || de != rows * ((cols + VS - 1) / VS) + 3) begin
        n_fail++;
        $display("FAIL rand_%0d_done_edges: got %0d want %0d", j, de, rows * ((cols + VS - 1) / VS) + 3);
      end
      wait_results(rows, to_r);
      n_checks++; if (got_q.size() != rows) begin n_fail++; $display("FAIL rand_%0d_count: got %0d want %0d", j, got_q.size(), rows); end
      for (int i = 0; i < rows && i < got_q.size(); i++) begin
        n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_%0d_value[%0d]: got %0h want %0h", j, i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tail();
    test_relu();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_full_size();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
